stage3_exe: RTL and testbench

STAGE3_EXE -- requirements
Module: stage3_exe

---
 rtl/exe_pkg.sv | 34 +++
 rtl/seq_muldiv.sv | 100 ++++++++++
 rtl/stage3_exe.sv | 97 +++++++++
 tb/tb_stage3_exe.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// rtl/exe_pkg.sv - alu_op codes, muldiv FSM states and helpers for stage3_exe
package exe_pkg;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_SLT = 4'h5;
    localparam logic [3:0] OP_SLL = 4'h6;
    localparam logic [3:0] OP_SRL = 4'h7;
    localparam logic [3:0] OP_SRA = 4'h8;
    localparam logic [3:0] OP_LUI = 4'h9;
    localparam logic [3:0] OP_MUL = 4'hA;
    localparam logic [3:0] OP_DIV = 4'hB;
    localparam logic [3:0] OP_REM = 4'hC;

    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } md_state_t;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? -v : v;
    endfunction

endpackage

// File: rtl/seq_muldiv.sv
// rtl/seq_muldiv.sv - radix-2 iterative MUL/DIV/REM, one bit per cycle over 32 cycles
module seq_muldiv
    import exe_pkg::*;
(
    input  logic        clk,
    input  logic        rstb,
    input  logic        start,
    input  logic        kill,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    md_state_t   r_state;
    logic [4:0]  r_cnt;
    logic [3:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_acc;
    logic [31:0] r_dvd;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_dz;
    logic [32:0] w_sh;
    logic [32:0] w_diff;

    // Divide uses r_a as |divisor|, r_b as dividend shifting into quotient, r_acc as remainder.
    assign w_sh   = {r_acc, r_b[31]};
    assign w_diff = w_sh - {1'b0, r_a};
    assign busy   = (r_state == ST_BUSY) || ((r_state == ST_IDLE) && start);
    assign done   = (r_state == ST_DONE);

    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_dvd   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
        end else if (kill) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (start) begin
                    r_state <= ST_BUSY;
                    r_cnt   <= '0;
                    r_op    <= op;
                    r_acc   <= '0;
                    r_dvd   <= a;
                    r_dz    <= (b == '0);
                    r_neg_q <= a[31] ^ b[31];
                    r_neg_r <= a[31];
                    if (op == OP_MUL) begin
                        r_a <= a;
                        r_b <= b;
                    end else begin
                        r_a <= abs32(b);
                        r_b <= abs32(a);
                    end
                end
                ST_BUSY: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31)
                        r_state <= ST_DONE;
                    if (r_op == OP_MUL) begin
                        if (r_b[0])
                            r_acc <= r_acc + r_a;
                        r_a <= r_a << 1;
                        r_b <= r_b >> 1;
                    end else if (!w_diff[32]) begin
                        r_acc <= w_diff[31:0];
                        r_b   <= {r_b[30:0], 1'b1};
                    end else begin
                        r_acc <= w_sh[31:0];
                        r_b   <= {r_b[30:0], 1'b0};
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        result = r_acc;
        if (r_op == OP_DIV)
            result = r_dz ? DIV_BY_ZERO_Q : (r_neg_q ? -r_b : r_b);
        else if (r_op == OP_REM)
            result = r_dz ? r_dvd : (r_neg_r ? -r_acc : r_acc);
    end

endmodule

// File: rtl/stage3_exe.sv
// rtl/stage3_exe.sv - execute stage: 1-cycle ALU, optional iterative muldiv (EXE_MULDIV_EN)
module stage3_exe
    import exe_pkg::*;
#(
    parameter int DATA_W = 32
)
(
    input  logic              clk,
    input  logic              rstb,
    input  logic              in_valid,
    input  logic              flush,
    input  logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] opA_in,
    input  logic [DATA_W-1:0] opB_in,
    input  logic [DATA_W-1:0] regB_rd_data_in,
    input  logic [4:0]        reg_wr_addr_in,
    input  logic              mem_wr_en_in,
    input  logic              mem_rd_en_in,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [DATA_W-1:0] regB_rd_data_out,
    output logic [4:0]        reg_wr_addr_out,
    output logic              mem_wr_en_out,
    output logic              mem_rd_en_out,
    output logic              ex_stall
);

    logic [DATA_W-1:0] w_alu;
    logic [DATA_W-1:0] w_result;
    logic [4:0]        w_shamt;
    logic              w_is_md;
    logic              w_drop;

    assign w_shamt = opB_in[4:0];
    assign w_is_md = is_muldiv(alu_op);

    always_comb begin
        w_alu = opA_in;
        case (alu_op)
            OP_ADD: w_alu = opA_in + opB_in;
            OP_SUB: w_alu = opA_in - opB_in;
            OP_AND: w_alu = opA_in & opB_in;
            OP_OR:  w_alu = opA_in | opB_in;
            OP_XOR: w_alu = opA_in ^ opB_in;
            OP_SLT: w_alu = {{(DATA_W-1){1'b0}}, ($signed(opA_in) < $signed(opB_in))};
            OP_SLL: w_alu = opA_in << w_shamt;
            OP_SRL: w_alu = opA_in >> w_shamt;
            OP_SRA: w_alu = $signed(opA_in) >>> w_shamt;
            OP_LUI: w_alu = opB_in << 16;
            default: w_alu = opA_in;
        endcase
    end

`ifdef EXE_MULDIV_EN
    logic              w_md_busy;
    logic              w_md_done;
    logic [DATA_W-1:0] w_md_result;

    seq_muldiv u_seq_muldiv (
        .clk    (clk),
        .rstb   (rstb),
        .start  (in_valid && w_is_md && !flush),
        .kill   (flush),
        .op     (alu_op),
        .a      (opA_in),
        .b      (opB_in),
        .busy   (w_md_busy),
        .done   (w_md_done),
        .result (w_md_result)
    );

    // A muldiv op only reaches the output registers from the DONE cycle.
    assign ex_stall = !flush && w_md_busy;
    assign w_result = w_is_md ? w_md_result : w_alu;
    assign w_drop   = flush || ex_stall || !in_valid || (w_is_md && !w_md_done);
`else
    assign ex_stall = 1'b0;
    assign w_result = w_alu;
    assign w_drop   = flush || !in_valid || w_is_md;
`endif

    always_ff @(posedge clk) begin
        if (!rstb || w_drop) begin
            alu_result_out   <= '0;
            regB_rd_data_out <= '0;
            reg_wr_addr_out  <= '0;
            mem_wr_en_out    <= 1'b0;
            mem_rd_en_out    <= 1'b0;
        end else begin
            alu_result_out   <= w_result;
            regB_rd_data_out <= regB_rd_data_in;
            reg_wr_addr_out  <= reg_wr_addr_in;
            mem_wr_en_out    <= mem_wr_en_in;
            mem_rd_en_out    <= mem_rd_en_in;
        end
    end

endmodule

// File: tb/tb_stage3_exe.sv
// tb/tb_stage3_exe.sv - randomized self-checking bench for stage3_exe against a behavioural model
module tb_stage3_exe;

`ifdef EXE_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstb, in_valid, flush, mem_wr_en_in, mem_rd_en_in;
    logic [3:0]  alu_op;
    logic [31:0] opA_in, opB_in, regB_rd_data_in;
    logic [4:0]  reg_wr_addr_in;
    logic [31:0] alu_result_out, regB_rd_data_out;
    logic [4:0]  reg_wr_addr_out;
    logic        mem_wr_en_out, mem_rd_en_out, ex_stall;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stage3_exe #(.DATA_W(32)) dut (
        .clk              (clk),
        .rstb             (rstb),
        .in_valid         (in_valid),
        .flush            (flush),
        .alu_op           (alu_op),
        .opA_in           (opA_in),
        .opB_in           (opB_in),
        .regB_rd_data_in  (regB_rd_data_in),
        .reg_wr_addr_in   (reg_wr_addr_in),
        .mem_wr_en_in     (mem_wr_en_in),
        .mem_rd_en_in     (mem_rd_en_in),
        .alu_result_out   (alu_result_out),
        .regB_rd_data_out (regB_rd_data_out),
        .reg_wr_addr_out  (reg_wr_addr_out),
        .mem_wr_en_out    (mem_wr_en_out),
        .mem_rd_en_out    (mem_rd_en_out),
        .ex_stall         (ex_stall)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [70:0] outs();
        return {alu_result_out, regB_rd_data_out, reg_wr_addr_out, mem_wr_en_out, mem_rd_en_out};
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic [63:0]        prod;
        int                 sh;
        sa = a;
        sb = b;
        sh = int'(b % 32);
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            4'h5: return (sa < sb) ? 32'd1 : 32'd0;
            4'h6: return a << sh;
            4'h7: return a >> sh;
            4'h8: return sa >>> sh;
            4'h9: return b * 32'd65536;
            4'hA: begin prod = a * b; return prod[31:0]; end
            4'hB: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            4'hC: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb;
            end
            default: return a;
        endcase
    endfunction

    // Presents one instruction, holds it through any stall, and checks the captured outputs.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] rb, input logic [4:0] wa, input logic wr, input logic rd);
        int stalls, bad_bubbles, exp_stalls;
        logic st, md;
        logic [70:0] exp_o;
        in_valid = 1'b1; alu_op = op; opA_in = a; opB_in = b;
        regB_rd_data_in = rb; reg_wr_addr_in = wa; mem_wr_en_in = wr; mem_rd_en_in = rd;
        stalls = 0; bad_bubbles = 0;
        for (int n = 0; n < 100; n++) begin
            #1;
            st = ex_stall;
            @(posedge clk);
            #1;
            if (!st) break;
            stalls++;
            if (outs() != '0) bad_bubbles++;
        end
        md = (op >= 4'hA && op <= 4'hC);
        exp_stalls = (md && MD) ? 33 : 0;
        if (md && !MD) exp_o = '0;
        else           exp_o = {ref_alu(op, a, b), rb, wa, wr, rd};
        chk({tag, "_stall"}, 64'(stalls), 64'(exp_stalls));
        chk({tag, "_bubble"}, 64'(bad_bubbles), 64'd0);
        chk({tag, "_res"}, 64'(outs() >> 39), 64'(exp_o >> 39));
        chk({tag, "_side"}, 64'(outs() & 71'h7F_FFFF_FFFF), 64'(exp_o & 71'h7F_FFFF_FFFF));
        in_valid = 1'b0;
    endtask

    task automatic idle_cycle(input string tag);
        in_valid = 1'b0;
        alu_op = 4'($urandom); opA_in = $urandom; opB_in = $urandom;
        reg_wr_addr_in = 5'($urandom); mem_wr_en_in = 1'b1; mem_rd_en_in = 1'b1;
        @(posedge clk);
        #1;
        chk(tag, 64'(outs() != '0), 64'd0);
    endtask

    initial begin
        int late;
        logic [31:0] ra, rbv;
        rstb = 1'b0; in_valid = 1'b0; flush = 1'b0; alu_op = '0;
        opA_in = '0; opB_in = '0; regB_rd_data_in = '0; reg_wr_addr_in = '0;
        mem_wr_en_in = 1'b0; mem_rd_en_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", 64'(outs() != '0), 64'd0);
        chk("reset_stall", 64'(ex_stall), 64'd0);
        rstb = 1'b1;

        run_op("add_wrap", 4'h0, 32'h7FFF_FFFF, 32'd1, 32'h1234, 5'd5, 1'b0, 1'b0);
        idle_cycle("bubble_after_add");
        run_op("sra", 4'h8, 32'h8000_0000, 32'd4, 32'h0, 5'd3, 1'b0, 1'b1);
        run_op("slt", 4'h5, 32'hFFFF_FFFF, 32'd1, 32'h0, 5'd7, 1'b1, 1'b0);
        run_op("mul", 4'hA, 32'hFFFF_FFFF, 32'd3, 32'hCAFE, 5'd9, 1'b0, 1'b0);
        run_op("div_neg", 4'hB, 32'hFFFF_FFF9, 32'd2, 32'h0, 5'd1, 1'b0, 1'b0);
        run_op("rem_neg", 4'hC, 32'hFFFF_FFF9, 32'd2, 32'h0, 5'd2, 1'b0, 1'b0);
        run_op("div_zero", 4'hB, 32'd5, 32'd0, 32'h0, 5'd4, 1'b0, 1'b0);
        run_op("rem_zero", 4'hC, 32'd5, 32'd0, 32'h0, 5'd4, 1'b0, 1'b0);
        run_op("div_ovf", 4'hB, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 5'd6, 1'b0, 1'b0);
        run_op("mul_b2b", 4'hA, 32'd7, 32'd6, 32'h0, 5'd8, 1'b0, 1'b0);

        // Flush ten cycles into a multiply.
        in_valid = 1'b1; alu_op = 4'hA; opA_in = 32'd11; opB_in = 32'd13; reg_wr_addr_in = 5'd10;
        repeat (10) @(posedge clk);
        #1;
        chk("flush_pre_stall", 64'(ex_stall), 64'(MD));
        flush = 1'b1;
        #1;
        chk("flush_stall", 64'(ex_stall), 64'd0);
        @(posedge clk);
        #1;
        chk("flush_bubble", 64'(outs() != '0), 64'd0);
        flush = 1'b0;
        run_op("after_flush", 4'h0, 32'd100, 32'd23, 32'h0, 5'd12, 1'b0, 1'b0);

        // Reset twenty cycles into a multiply; nothing may emerge afterwards.
        in_valid = 1'b1; alu_op = 4'hA; opA_in = 32'd5; opB_in = 32'd9; reg_wr_addr_in = 5'd14;
        repeat (20) @(posedge clk);
        #1;
        rstb = 1'b0; in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("midreset_outs", 64'(outs() != '0), 64'd0);
        rstb = 1'b1;
        #1;
        chk("midreset_stall", 64'(ex_stall), 64'd0);
        late = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (outs() != '0 || ex_stall) late++;
        end
        chk("midreset_late", 64'(late), 64'd0);

        for (int i = 0; i < 40; i++) begin
            ra  = $urandom;
            rbv = $urandom;
            case ($urandom_range(0, 7))
                0: rbv = 32'($urandom_range(0, 2));
                1: begin ra = 32'h8000_0000; rbv = 32'hFFFF_FFFF; end
                2: rbv = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: ;
            endcase
            run_op($sformatf("rnd%0d", i), 4'($urandom_range(0, 15)), ra, rbv, $urandom,
                   5'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 2) == 0) idle_cycle($sformatf("rnd_idle%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
